// File: rtl/spill_flush_arbiter.sv
// spill_flush_arbiter: round-robin arbiter and flush sequencer in front of one flushable spill register
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   req_valid_i/req_ready_o       per-requester handshake (ready is one-hot or zero)
//   req_data_i                    packed payloads, requester i at [i*DataWidth +: DataWidth]
//   spill_valid_o/spill_ready_i   handshake to the spill register
//   spill_data_o, grant_idx_o     payload and index of the granted requester
//   spill_flush_o                 one-cycle flush strobe, never together with spill_valid_o
//   flush_req_i, flush_ack_o      level flush request, one-cycle completion pulse
module spill_flush_arbiter #(
    parameter int NumIn     = 4,
    parameter int DataWidth = 32,
    parameter int IdxW      = $clog2(NumIn)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NumIn-1:0]           req_valid_i,
    output logic [NumIn-1:0]           req_ready_o,
    input  logic [NumIn*DataWidth-1:0] req_data_i,
    output logic                       spill_valid_o,
    input  logic                       spill_ready_i,
    output logic [DataWidth-1:0]       spill_data_o,
    output logic                       spill_flush_o,
    output logic [IdxW-1:0]            grant_idx_o,
    input  logic                       flush_req_i,
    output logic                       flush_ack_o
);
    typedef enum logic [1:0] {IDLE, LOCKED, FLUSH, ACK} state_t;
    state_t state;
    logic [IdxW-1:0] rr_q, lock_idx_q, g, sel, nxt;
    logic [IdxW:0] j;
    // Scan from the highest offset down so the requester closest to rr_q wins.
    always_comb begin
        g = rr_q;
        j = '0;
        for (int k = NumIn - 1; k >= 0; k--) begin
            j = {1'b0, rr_q} + (IdxW+1)'(k);
            j = (j >= (IdxW+1)'(NumIn)) ? j - (IdxW+1)'(NumIn) : j;
            g = req_valid_i[j[IdxW-1:0]] ? j[IdxW-1:0] : g;
        end
    end
    assign sel           = (state == LOCKED) ? lock_idx_q : g;
    // Explicit wrap keeps the pointer inside 0..NumIn-1 for non-power-of-2 NumIn.
    assign nxt           = (sel == IdxW'(NumIn - 1)) ? '0 : sel + 1'b1;
    assign spill_valid_o = (state == LOCKED) || (state == IDLE && !flush_req_i && |req_valid_i);
    assign spill_data_o  = req_data_i[sel*DataWidth +: DataWidth];
    assign grant_idx_o   = sel;
    assign req_ready_o   = spill_valid_o ? (NumIn'(spill_ready_i) << sel) : '0;
    assign spill_flush_o = (state == FLUSH);
    assign flush_ack_o   = (state == ACK);
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            rr_q       <= '0;
            lock_idx_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush_req_i) state <= FLUSH;
                    else if (|req_valid_i && spill_ready_i) rr_q <= nxt;
                    else if (|req_valid_i) begin
                        lock_idx_q <= g;
                        state      <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (spill_ready_i) begin
                        rr_q  <= nxt;
                        state <= IDLE;
                    end
                end
                FLUSH:   state <= ACK;
                default: state <= IDLE;
            endcase
        end
    end
    always @(posedge clk_i) if (rst_ni) assert (!(spill_flush_o && spill_valid_o));
endmodule

// File: tb/tb_spill_flush_arbiter.sv
// tb_spill_flush_arbiter: scoreboard bench for spill_flush_arbiter (NumIn=4 main instance, NumIn=3 wrap instance)
module tb_spill_flush_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n, ready, flush, sv, sf, ack;
    logic [3:0] valid, rdy;
    logic [127:0] data;
    logic [31:0] sd;
    logic [1:0] gi;
    logic [2:0] v3, rdy3;
    logic [23:0] d3;
    logic r3, sv3, sf3, ack3;
    logic [7:0] sd3;
    logic [1:0] gi3;
    spill_flush_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(valid), .req_ready_o(rdy), .req_data_i(data),
        .spill_valid_o(sv), .spill_ready_i(ready), .spill_data_o(sd), .spill_flush_o(sf),
        .grant_idx_o(gi), .flush_req_i(flush), .flush_ack_o(ack)
    );
    spill_flush_arbiter #(.NumIn(3), .DataWidth(8)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(v3), .req_ready_o(rdy3), .req_data_i(d3),
        .spill_valid_o(sv3), .spill_ready_i(r3), .spill_data_o(sd3), .spill_flush_o(sf3),
        .grant_idx_o(gi3), .flush_req_i(1'b0), .flush_ack_o(ack3)
    );
    typedef struct {logic [1:0] idx; logic [31:0] dat;} exp_t;
    exp_t q[$];
    exp_t e;
    int total = 0, bad = 0;
    function automatic logic [31:0] dval(int i);
        return 32'hC0DE_0000 + 32'(i) * 32'h111;
    endfunction
    task automatic push(int i);
        q.push_back('{idx: 2'(i), dat: dval(i)});
    endtask
    always @(negedge clk) begin
        if (rst_n && sv && ready) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL hs_unexpected got idx=%0d data=%h want no handshake", gi, sd);
            end else begin
                e = q.pop_front();
                if (gi !== e.idx || sd !== e.dat) begin
                    bad++;
                    $display("FAIL hs_payload got idx=%0d data=%h want idx=%0d data=%h", gi, sd, e.idx, e.dat);
                end
            end
        end
    end
    task automatic test_reset;
        rst_n = 1'b0; valid = '0; ready = 1'b0; flush = 1'b0; v3 = '0; r3 = 1'b0;
        for (int i = 0; i < 4; i++) data[i*32 +: 32] = dval(i);
        for (int i = 0; i < 3; i++) d3[i*8 +: 8] = 8'h50 + 8'(i);
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({sv, sf, ack, rdy} !== 7'b0) begin
            bad++;
            $display("FAIL reset got sv=%b sf=%b ack=%b rdy=%b want all zero", sv, sf, ack, rdy);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask
    task automatic test_rotation;
        valid = 4'b1111; ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            int x = k % 4;
            push(x);
            @(negedge clk);
            total++;
            if (gi !== 2'(x) || rdy !== 4'(1 << x) || sv !== 1'b1) begin
                bad++;
                $display("FAIL rotation[%0d] got idx=%0d rdy=%b sv=%b want idx=%0d rdy=%b sv=1", k, gi, rdy, sv, x, 4'(1 << x));
            end
            @(posedge clk); #1;
        end
        valid = '0; ready = 1'b0;
    endtask
    task automatic test_lock;
        valid = 4'b0100; ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (sv !== 1'b1 || gi !== 2'd2 || sd !== dval(2) || rdy !== 4'b0) begin
                bad++;
                $display("FAIL lock_hold[%0d] got sv=%b idx=%0d data=%h rdy=%b want 1 2 %h 0000", k, sv, gi, sd, rdy, dval(2));
            end
            @(posedge clk); #1;
            valid = 4'b0111;
        end
        ready = 1'b1; push(2);
        @(negedge clk);
        total++;
        if (rdy !== 4'b0100) begin
            bad++;
            $display("FAIL lock_release got rdy=%b want 0100", rdy);
        end
        @(posedge clk); #1;
        valid = 4'b1011; push(3);
        @(negedge clk);
        total++;
        if (gi !== 2'd3) begin
            bad++;
            $display("FAIL lock_next got idx=%0d want 3", gi);
        end
        @(posedge clk); #1;
        valid = '0; ready = 1'b0;
    endtask
    task automatic test_flush_idle;
        valid = 4'b0010; ready = 1'b1; flush = 1'b1;
        @(negedge clk);
        total++;
        if (sv !== 1'b0 || rdy !== 4'b0 || sf !== 1'b0) begin
            bad++;
            $display("FAIL flush_idle_req got sv=%b rdy=%b sf=%b want 0 0000 0", sv, rdy, sf);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        total++;
        if (sf !== 1'b1 || sv !== 1'b0 || rdy !== 4'b0 || ack !== 1'b0) begin
            bad++;
            $display("FAIL flush_idle_strobe got sf=%b sv=%b rdy=%b ack=%b want 1 0 0000 0", sf, sv, rdy, ack);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (ack !== 1'b1 || sf !== 1'b0 || sv !== 1'b0 || rdy !== 4'b0) begin
            bad++;
            $display("FAIL flush_idle_ack got ack=%b sf=%b sv=%b rdy=%b want 1 0 0 0000", ack, sf, sv, rdy);
        end
        @(posedge clk); #1;
        push(1);
        @(negedge clk);
        total++;
        if (sv !== 1'b1 || gi !== 2'd1 || ack !== 1'b0) begin
            bad++;
            $display("FAIL flush_idle_after got sv=%b idx=%0d ack=%b want 1 1 0", sv, gi, ack);
        end
        @(posedge clk); #1;
        valid = '0; ready = 1'b0;
    endtask
    task automatic test_flush_locked;
        valid = 4'b0001; ready = 1'b0;
        @(negedge clk);
        total++;
        if (sv !== 1'b1 || gi !== 2'd0) begin
            bad++;
            $display("FAIL flock_grant got sv=%b idx=%0d want 1 0", sv, gi);
        end
        @(posedge clk); #1;
        flush = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++;
            if (sv !== 1'b1 || gi !== 2'd0 || sf !== 1'b0 || rdy !== 4'b0) begin
                bad++;
                $display("FAIL flock_hold[%0d] got sv=%b idx=%0d sf=%b rdy=%b want 1 0 0 0000", k, sv, gi, sf, rdy);
            end
            @(posedge clk); #1;
        end
        ready = 1'b1; push(0);
        @(negedge clk);
        total++;
        if (rdy !== 4'b0001 || sf !== 1'b0) begin
            bad++;
            $display("FAIL flock_hs got rdy=%b sf=%b want 0001 0", rdy, sf);
        end
        @(posedge clk); #1;
        valid = '0; ready = 1'b0;
        @(negedge clk);
        total++;
        if (sv !== 1'b0 || sf !== 1'b0) begin
            bad++;
            $display("FAIL flock_idle got sv=%b sf=%b want 0 0", sv, sf);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (sf !== 1'b1 || sv !== 1'b0) begin
            bad++;
            $display("FAIL flock_strobe got sf=%b sv=%b want 1 0", sf, sv);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (ack !== 1'b1 || sf !== 1'b0) begin
            bad++;
            $display("FAIL flock_ack got ack=%b sf=%b want 1 0", ack, sf);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        total++;
        if (ack !== 1'b0 || sf !== 1'b0 || sv !== 1'b0) begin
            bad++;
            $display("FAIL flock_done got ack=%b sf=%b sv=%b want 0 0 0", ack, sf, sv);
        end
        @(posedge clk); #1;
    endtask
    task automatic test_reset_in_flush;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        total++;
        if (sf !== 1'b1) begin
            bad++;
            $display("FAIL rflush_strobe got sf=%b want 1", sf);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (sf !== 1'b0 || ack !== 1'b0 || sv !== 1'b0) begin
            bad++;
            $display("FAIL rflush_async got sf=%b ack=%b sv=%b want 0 0 0", sf, ack, sv);
        end
        @(posedge clk); #1;
        total++;
        if (ack !== 1'b0) begin
            bad++;
            $display("FAIL rflush_noack got ack=%b want 0", ack);
        end
        rst_n = 1'b1;
        valid = 4'b1111; ready = 1'b1; push(0);
        @(negedge clk);
        total++;
        if (gi !== 2'd0) begin
            bad++;
            $display("FAIL rflush_ptr got idx=%0d want 0", gi);
        end
        @(posedge clk); #1;
        valid = '0; ready = 1'b0;
    endtask
    task automatic test_wrap3;
        logic [1:0] want_i[4] = '{2'd1, 2'd2, 2'd0, 2'd1};
        logic [2:0] want_v[4] = '{3'b010, 3'b100, 3'b111, 3'b111};
        r3 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            v3 = want_v[k];
            @(negedge clk);
            total++;
            if (sv3 !== 1'b1 || gi3 !== want_i[k] || rdy3 !== 3'(1 << want_i[k]) || sd3 !== 8'h50 + 8'(want_i[k])) begin
                bad++;
                $display("FAIL wrap3[%0d] got sv=%b idx=%0d rdy=%b data=%h want 1 %0d %b %h", k, sv3, gi3, rdy3, sd3, want_i[k], 3'(1 << want_i[k]), 8'h50 + 8'(want_i[k]));
            end
            @(posedge clk); #1;
        end
        v3 = '0; r3 = 1'b0;
    endtask
    initial begin
        test_reset;
        test_rotation;
        test_lock;
        test_flush_idle;
        test_flush_locked;
        test_reset_in_flush;
        test_wrap3;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
